// File: rtl/fft_bin_reorder_pkg.sv
// fft_bin_reorder shared types: default sizes
// and the write/read controller state encodings.
package fft_bin_reorder_pkg;

  localparam int TOTAL_STAGE = 10;
  localparam int REAL_WIDTH  = 16;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rstate_t;

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port and one
// registered read port that holds while re is low.
module fft_dpram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bin_reorder.sv
// Captures FFT frames in any bin order into a ping-pong
// buffer and streams them out in natural order with power.
module fft_bin_reorder
  import fft_bin_reorder_pkg::*;
#(
  parameter int STAGE = TOTAL_STAGE,
  parameter int DW    = REAL_WIDTH
) (
  input  logic              iclk,
  input  logic              rst_n,
  input  logic [STAGE-1:0]  iaddr,
  input  logic [DW-1:0]     iReal,
  input  logic [DW-1:0]     iImag,
  input  logic              ien,
  output logic [DW-1:0]     oReal,
  output logic [DW-1:0]     oImag,
  output logic [2*DW-1:0]   oPow,
  output logic [STAGE-1:0]  oaddr,
  output logic              ovalid,
  input  logic              oready,
  output logic              osof,
  output logic              oeof,
  output logic              ovf
);

  wstate_t ws, ws_nxt;
  rstate_t rs, rs_nxt;

  logic [STAGE-1:0] wcnt;
  logic [STAGE-1:0] ridx;
  logic [STAGE-1:0] s1_idx;
  logic             wb;
  logic             rb;
  logic             rdone;
  logic             s1_valid;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic w_last;
  logic fill_done;
  logic rel;
  logic w_ok;
  logic wen;
  logic ren;
  logic out_ready;
  logic out_load;

  logic [2*DW-1:0]        rdata;
  logic [DW-1:0]          rd_re;
  logic [DW-1:0]          rd_im;
  logic signed [2*DW-1:0] re_x;
  logic signed [2*DW-1:0] im_x;
  logic [2*DW-1:0]        pow;

  assign w_last    = ien && (wcnt == '1);
  assign fill_done = (ws == W_FILL) && w_last;
  assign rel       = ovalid && oready && oeof;
  // a bank released on this edge may be refilled at once
  assign w_ok      = !full[wb] || (rel && (rb == wb));
  assign out_ready = !ovalid || oready;
  assign out_load  = s1_valid && out_ready;
  assign ren       = (rs == R_READ) && !rdone &&
                     (!s1_valid || out_ready);

  always_comb begin
    ws_nxt = ws;
    wen    = 1'b0;
    unique case (ws)
      W_IDLE: begin
        if (ien) begin
          if (w_ok) begin
            wen    = 1'b1;
            ws_nxt = W_FILL;
          end else begin
            ws_nxt = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (ien) begin
          wen = 1'b1;
          if (w_last) ws_nxt = W_IDLE;
        end
      end
      W_DROP: begin
        if (w_last) ws_nxt = W_IDLE;
      end
      default: ws_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rs_nxt = rs;
    unique case (rs)
      R_IDLE:  if (full[rb]) rs_nxt = R_READ;
      R_READ:  if (rel) rs_nxt = R_IDLE;
      default: rs_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    full_nxt = full;
    if (rel)       full_nxt[rb] = 1'b0;
    if (fill_done) full_nxt[wb] = 1'b1;
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      ws   <= W_IDLE;
      rs   <= R_IDLE;
      wcnt <= '0;
      wb   <= 1'b0;
      rb   <= 1'b0;
      full <= '0;
      ovf  <= 1'b0;
    end else begin
      ws   <= ws_nxt;
      rs   <= rs_nxt;
      full <= full_nxt;
      if (ien) wcnt <= wcnt + STAGE'(1);
      if ((ws == W_IDLE) && ien && !w_ok) ovf <= 1'b1;
      if (fill_done) wb <= !wb;
      if (rel) rb <= !rb;
    end
  end

  // issue side and RAM-output stage bookkeeping
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      ridx     <= '0;
      rdone    <= 1'b0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
    end else begin
      if (rs == R_IDLE) begin
        ridx  <= '0;
        rdone <= 1'b0;
      end else if (ren) begin
        ridx <= ridx + STAGE'(1);
        if (ridx == '1) rdone <= 1'b1;
      end
      if (ren) begin
        s1_valid <= 1'b1;
        s1_idx   <= ridx;
      end else if (out_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  fft_dpram #(
    .DEPTH (2 ** (STAGE + 1)),
    .WIDTH (2 * DW),
    .AW    (STAGE + 1)
  ) u_ram (
    .clk   (iclk),
    .we    (wen),
    .waddr ({wb, iaddr}),
    .wdata ({iReal, iImag}),
    .re    (ren),
    .raddr ({rb, ridx}),
    .rdata (rdata)
  );

  assign rd_re = rdata[2*DW-1:DW];
  assign rd_im = rdata[DW-1:0];
  assign re_x  = {{DW{rd_re[DW-1]}}, rd_re};
  assign im_x  = {{DW{rd_im[DW-1]}}, rd_im};
  assign pow   = $unsigned(re_x * re_x) +
                 $unsigned(im_x * im_x);

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      oReal  <= '0;
      oImag  <= '0;
      oPow   <= '0;
      oaddr  <= '0;
      ovalid <= 1'b0;
      osof   <= 1'b0;
      oeof   <= 1'b0;
    end else if (out_load) begin
      oReal  <= rd_re;
      oImag  <= rd_im;
      oPow   <= pow;
      oaddr  <= s1_idx;
      ovalid <= 1'b1;
      osof   <= (s1_idx == '0);
      oeof   <= (s1_idx == '1);
    end else if (oready) begin
      ovalid <= 1'b0;
    end
  end

endmodule
